// File: rtl/shift_pkg.sv
// Shared opcode encoding and sequencer state type for the single-step shifter
// and the multi-step shift sequencer.
package shift_pkg;

  localparam logic [2:0] OP_MVB = 3'b000;
  localparam logic [2:0] OP_ASR = 3'b001;
  localparam logic [2:0] OP_LSR = 3'b010;
  localparam logic [2:0] OP_LSL = 3'b011;
  localparam logic [2:0] OP_RSR = 3'b100;
  localparam logic [2:0] OP_RSL = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // 110/111 alias MVB, so only 001..101 actually move bits.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_ASR) && (op <= OP_RSL);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational single-bit shift/rotate datapath; c is the bit shifted out.
module shift_step
  import shift_pkg::*;
#(
  parameter int BW = 8
) (
  input  logic [BW-1:0] din,
  input  logic [2:0]    op,
  output logic [BW-1:0] dout,
  output logic          c
);

  always_comb begin
    dout = din;
    c    = 1'b0;
    case (op)
      OP_ASR: begin
        dout = {din[BW-1], din[BW-1:1]};
        c    = din[0];
      end
      OP_LSR: begin
        dout = {1'b0, din[BW-1:1]};
        c    = din[0];
      end
      OP_LSL: begin
        dout = {din[BW-2:0], 1'b0};
        c    = din[BW-1];
      end
      OP_RSR: begin
        dout = {din[0], din[BW-1:1]};
        c    = din[0];
      end
      OP_RSL: begin
        dout = {din[BW-2:0], din[BW-1]};
        c    = din[BW-1];
      end
      default: begin
        dout = din;
        c    = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Multi-cycle shift sequencer: repeats one shift_step operation amt times
// on a working register, with a start/busy/done handshake.
module shift_seq
  import shift_pkg::*;
#(
  parameter int BW   = 8,
  parameter int CNTW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [BW-1:0]   din,
  input  logic [CNTW-1:0] amt,
  output logic            busy,
  output logic            done,
  output logic [BW-1:0]   dout,
  output logic            c
);

  state_t          state;
  logic [2:0]      op_q;
  logic [CNTW-1:0] count;
  logic [BW-1:0]   step_dout;
  logic            step_c;

  shift_step #(.BW(BW)) u_step (
    .din  (dout),
    .op   (op_q),
    .dout (step_dout),
    .c    (step_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      op_q  <= OP_MVB;
      count <= '0;
      dout  <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          // DONE accepts a new request too, giving back-to-back throughput.
          if (start) begin
            dout <= din;
            c    <= 1'b0;
            op_q <= op;
            if ((amt == '0) || !is_shift_op(op)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              count <= amt;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        RUN: begin
          dout  <= step_dout;
          c     <= step_c;
          count <= count - 1'b1;
          if (count == CNTW'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq: table of single requests plus hand sequences
// for ignored start, back-to-back requests and mid-run reset.
module tb_shift_seq;
  import shift_pkg::*;

  localparam int BW   = 8;
  localparam int CNTW = 4;
  localparam int BUDGET = 40;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      op = 3'b000;
  logic [BW-1:0]   din = '0;
  logic [CNTW-1:0] amt = '0;
  logic            busy, done, c;
  logic [BW-1:0]   dout;

  int total = 0;
  int bad = 0;

  shift_seq #(.BW(BW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .din(din), .amt(amt),
    .busy(busy), .done(done), .dout(dout), .c(c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    op;
    logic [BW-1:0] din;
    logic [3:0]    amt;
    logic [BW-1:0] dout;
    logic          c;
    int            lat;
    int            bcnt;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pulses start for one edge; returns the cycle (1 = cycle after start edge)
  // in which done was seen, busy cycle count and busy/done overlap count.
  task automatic run_req(input logic [2:0] o, input logic [BW-1:0] d,
                         input logic [3:0] a, output int lat, output int bcnt,
                         output int clash);
    int k;
    @(negedge clk);
    start = 1'b1; op = o; din = d; amt = a;
    @(negedge clk);
    start = 1'b0;
    k = 1; bcnt = 0; clash = 0;
    while (!done && k < BUDGET) begin
      if (busy) bcnt++;
      @(negedge clk);
      k++;
    end
    if (done && busy) clash++;
    lat = done ? k : -1;
  endtask

  initial begin
    int lat, bcnt, clash, k, pulses;

    vecs[0] = '{OP_ASR, 8'h86, 4'd3,  8'hF0, 1'b1, 4,  3};
    vecs[1] = '{OP_LSL, 8'h81, 4'd1,  8'h02, 1'b1, 2,  1};
    vecs[2] = '{OP_LSR, 8'h5A, 4'd0,  8'h5A, 1'b0, 1,  0};
    vecs[3] = '{OP_RSR, 8'h01, 4'd8,  8'h01, 1'b0, 9,  8};
    vecs[4] = '{3'b110, 8'h5A, 4'd5,  8'h5A, 1'b0, 1,  0};
    vecs[5] = '{OP_LSR, 8'hFF, 4'd10, 8'h00, 1'b0, 11, 10};
    vecs[6] = '{OP_ASR, 8'h80, 4'd9,  8'hFF, 1'b1, 10, 9};
    vecs[7] = '{OP_RSL, 8'h81, 4'd3,  8'h0C, 1'b0, 4,  3};
    vecs[8] = '{OP_LSL, 8'h01, 4'd7,  8'h80, 1'b0, 8,  7};
    vecs[9] = '{3'b111, 8'h3C, 4'd4,  8'h3C, 1'b0, 1,  0};

    // Reset state
    #12;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_c",    32'(c),    32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      run_req(vecs[i].op, vecs[i].din, vecs[i].amt, lat, bcnt, clash);
      check($sformatf("v%0d_lat", i),   32'(lat),     32'(vecs[i].lat));
      check($sformatf("v%0d_busy", i),  32'(bcnt),    32'(vecs[i].bcnt));
      check($sformatf("v%0d_clash", i), 32'(clash),   32'h0);
      check($sformatf("v%0d_dout", i),  32'(dout),    32'(vecs[i].dout));
      check($sformatf("v%0d_c", i),     32'(c),       32'(vecs[i].c));
      @(negedge clk);
      check($sformatf("v%0d_pulse", i), 32'(done),    32'h0);
    end

    // Start while busy is ignored; one done pulse; dout holds in IDLE
    @(negedge clk);
    start = 1'b1; op = OP_RSL; din = 8'h80; amt = 4'd2;
    @(negedge clk);
    start = 1'b1; op = OP_LSR; din = 8'hFF; amt = 4'd3;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; lat = -1;
    for (int j = 2; j < 12; j++) begin
      if (done) begin
        pulses++;
        if (lat < 0) lat = j;
      end
      @(negedge clk);
    end
    check("ign_lat",    32'(lat),    32'd3);
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_dout",   32'(dout),   32'h02);
    check("ign_c",      32'(c),      32'h0);

    // Back-to-back: new start held during the done cycle
    run_req(OP_LSL, 8'h81, 4'd1, lat, bcnt, clash);
    check("b2b_lat1", 32'(lat), 32'd2);
    start = 1'b1; op = OP_LSR; din = 8'h04; amt = 4'd2;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    while (!done && k < BUDGET) begin
      @(negedge clk);
      k++;
    end
    check("b2b_lat2", 32'(k),    32'd3);
    check("b2b_dout", 32'(dout), 32'h01);
    check("b2b_c",    32'(c),    32'h0);

    // Asynchronous reset after the third step
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; op = OP_LSR; din = 8'hFF; amt = 4'd6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_dout", 32'(dout), 32'h1F);
    check("mid_busy", 32'(busy), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dout", 32'(dout), 32'h0);
    check("arst_c",    32'(c),    32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_done", 32'(done), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0; bcnt = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) bcnt++;
    end
    check("post_done", 32'(pulses), 32'd0);
    check("post_busy", 32'(bcnt),   32'd0);
    check("post_dout", 32'(dout),   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
